// File: rtl/regfile_mp.sv
// Multi-port integer register file with two prioritised write ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     set_busy,
  input  logic [ADDR_W-1:0]        set_addr,
  output logic                     busy_any
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              w0;
  logic              w1;
  logic              w0_keep;
  logic              set_v;

  assign w0      = we0 && (waddr0 != '0);
  assign w1      = we1 && (waddr1 != '0);
  assign w0_keep = w0 && !(w1 && (waddr1 == waddr0));
  assign set_v   = set_busy && (set_addr != '0);

  // set is applied last so a newer producer wins over a retiring one
  always_comb begin
    busy_nxt = busy;
    if (w0) busy_nxt[waddr0] = 1'b0;
    if (w1) busy_nxt[waddr1] = 1'b0;
    if (set_v) busy_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (w0_keep) mem[waddr0] <= wdata0;
      if (w1) mem[waddr1] <= wdata1;
      busy <= busy_nxt;
    end
  end

  assign busy_any = |busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
    logic              set_hit;

    assign a       = raddr[k*ADDR_W +: ADDR_W];
    assign set_hit = set_busy && (set_addr == a);

    always_comb begin
      d = mem[a];
      b = busy[a];
      if (BYPASS != 0) begin
        if (w1 && (waddr1 == a)) begin
          d = wdata1;
          b = b & set_hit;
        end else if (w0 && (waddr0 == a)) begin
          d = wdata0;
          b = b & set_hit;
        end
      end
      if (rst || (a == '0)) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = d;
    assign rbusy[k]                  = b;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RISC-V core. It is the successor to the 2-read/1-write regfile and adds:
- configurable data width, depth and read-port count
- two write ports with fixed priority
- optional write-to-read bypass
- a per-register busy scoreboard that the issue stage uses to detect RAW hazards

It sits between decode/issue (reads, busy set) and writeback (writes, busy clear).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  input  1  clock, rising edge active
rst  input  1  asynchronous active-high reset
we0  input  1  write port 0 enable
waddr0  input  ADDR_W  write port 0 address
wdata0  input  DATA_W  write port 0 data
we1  input  1  write port 1 enable (higher priority)
waddr1  input  ADDR_W  write port 1 address
wdata1  input  DATA_W  write port 1 data
raddr  input  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rbusy  output  NUM_RD  busy flag of the register addressed by each read port
set_busy  input  1  mark register busy (instruction issued)
set_addr  input  ADDR_W  register to mark busy
busy_any  output  1  OR of all busy bits

Behaviour:
- Single clock domain, clk. rst is asynchronous and active-high:
  - all registers clear to 0, all busy bits clear to 0
  - rdata = 0, rbusy = 0, busy_any = 0 while rst is high
- Register 0 is hardwired to zero:
  - writes to address 0 are ignored on both ports
  - set_busy to address 0 is ignored
  - reads of address 0 return 0 and rbusy = 0, regardless of BYPASS
- Writes commit on the rising clk edge when weN=1 and waddrN != 0.
- Both ports writing the same address in one cycle: port 1 wins; port 0 data is discarded.
- Reads are combinational; the stored value is visible the cycle after the write edge.
- BYPASS=1: if a read address matches an active write this cycle (nonzero address), rdata takes that write's data in the same cycle. Port 1 has priority over port 0.
- BYPASS=0: rdata shows the pre-edge stored value during the write cycle.
- Scoreboard, one busy bit per register, updated on the rising edge:
  - set_busy=1 sets busy[set_addr]
  - an active write (we0 or we1, nonzero address) clears busy[waddr]
  - set and clear on the same address in the same cycle: set wins, so the bit stays 1 (a newer producer has issued)
  - setting an already-busy bit keeps it 1; clearing a non-busy bit is harmless
- rbusy[k] = busy[raddr_k]. When BYPASS=1 it reads 0 if a write to that address is active this cycle and no same-cycle set targets it; this combinational view matches the bypassed data.
- busy_any reflects the registered busy bits only, with no bypass.
- Reset asserted mid-operation: all state clears immediately. Writes and sets presented in the reset cycle are lost.
- No X propagation: all outputs are defined whenever inputs are known.
- Width rules: addresses are compared on the full ADDR_W bits; no truncation of data.

Test Plan:
1. Reset, then read all ports at addresses 0..31 -> every rdata = 0x00000000, rbusy = 0, busy_any = 0.
2. we0, addr 1, 0x12345678 and we1, addr 2, 0xABCDEF01 in the same cycle; next cycle read ports 0/1 at 1/2 -> 0x12345678 / 0xABCDEF01.
3. Both ports write addr 3 (port 0 0x11111111, port 1 0xCAFEBABE) with BYPASS=1, read port 0 at addr 3 the same cycle -> rdata0 = 0xCAFEBABE combinationally and still 0xCAFEBABE after the edge. With BYPASS=0 the same-cycle rdata0 is the old value (0).
4. we1 to addr 0 with 0xDEADBEEF, plus set_busy addr 0 -> reading addr 0 gives 0 and rbusy = 0; busy_any stays 0.
5. Scoreboard sequence:
   - set_busy addr 5 -> next cycle rbusy for addr 5 = 1, busy_any = 1
   - same-cycle set_busy addr 5 and we0 addr 5 -> bit stays 1
   - next cycle we0 addr 5 alone with 0x0000BEEF -> rbusy is 0 combinationally during that cycle (BYPASS=1), busy_any = 0 after the edge, rdata = 0x0000BEEF
6. Write addr 7 with 0x55AA55AA and set_busy addr 8, then assert rst asynchronously mid-cycle (between edges) -> rdata for addr 7 = 0 and busy_any = 0 before the next edge. After release, a write to addr 7 works normally.
